// File: rtl/decoder_rr_arbiter_if.sv
// decoder_rr_arbiter_if
//   Bundle between the eight requesters and the shared 3-to-8 active-low
//   select decoder.
//   req        requester -> arbiter, one level per channel
//   A0..A2     decoder address (owner index)
//   G1,G2A,G2B decoder enables (G1 high / G2x low while granted)
//   Y          registered active-low one-hot select copy
//   gnt_valid  high while a grant is being driven
interface decoder_rr_arbiter_if;
  logic [7:0] req;
  logic       A0, A1, A2;
  logic       G1, G2A, G2B;
  logic [7:0] Y;
  logic       gnt_valid;

  modport master (output req, input A0, A1, A2, G1, G2A, G2B, Y, gnt_valid);
  modport slave  (input req, output A0, A1, A2, G1, G2A, G2B, Y, gnt_valid);
endinterface

// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter
//   Round-robin owner selection for one shared 3-to-8 active-low decoder.
//   Holds a contested grant for HOLD_MAX cycles, and always inserts one
//   all-deselected cycle between owners (break-before-make).
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of decoder_rr_arbiter_if (req in, decoder lines out)
module decoder_rr_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decoder_rr_arbiter_if.slave  bus
);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t     r_state;
  logic [2:0] r_owner, r_last;
  logic [7:0] r_hold_cnt;
  logic [2:0] r_addr;
  logic       r_g1, r_g2;
  logic [7:0] r_y;
  logic       r_gv;

  logic [2:0] w_pick;
  logic       w_any, w_others, w_preempt;

  // Search last+1 .. last+8; last+8 wraps to last, so the previous owner
  // is considered only after everyone else.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] last);
    logic [2:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = last + 3'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign w_pick    = rr_pick(bus.req, r_last);
  assign w_any     = |bus.req;
  assign w_others  = |(bus.req & ~(8'b1 << r_owner));
  assign w_preempt = (r_hold_cnt == HOLD_LAST) && w_others;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner    <= 3'd0;
      r_last     <= 3'd7;
      r_hold_cnt <= 8'd0;
      r_addr     <= 3'd0;
      r_g1       <= 1'b0;
      r_g2       <= 1'b1;
      r_y        <= 8'hFF;
      r_gv       <= 1'b0;
    end else begin
      case (r_state)
        IDLE, GAP: begin
          if (w_any) begin
            r_state    <= GRANT;
            r_owner    <= w_pick;
            r_last     <= w_pick;
            r_hold_cnt <= 8'd0;
            r_addr     <= w_pick;
            r_g1       <= 1'b1;
            r_g2       <= 1'b0;
            r_y        <= ~(8'b1 << w_pick);
            r_gv       <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        GRANT: begin
          // Release and preemption both land in GAP; address is left as-is.
          if (!bus.req[r_owner] || w_preempt) begin
            r_state <= GAP;
            r_g1    <= 1'b0;
            r_g2    <= 1'b1;
            r_y     <= 8'hFF;
            r_gv    <= 1'b0;
          end else if (r_hold_cnt != HOLD_LAST) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.A0        = r_addr[0];
  assign bus.A1        = r_addr[1];
  assign bus.A2        = r_addr[2];
  assign bus.G1        = r_g1;
  assign bus.G2A       = r_g2;
  assign bus.G2B       = r_g2;
  assign bus.Y         = r_y;
  assign bus.gnt_valid = r_gv;
endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// tb_decoder_rr_arbiter
//   Drives two arbiters (HOLD_MAX=4 and HOLD_MAX=1) from the same request
//   vector and compares every decoder line each cycle against a tenure-based
//   reference model of the round-robin rules.
module tb_decoder_rr_arbiter;
  logic       gclk;
  logic       rst_n;
  logic [7:0] req;

  int vec_cnt = 0;
  int err_cnt = 0;

  decoder_rr_arbiter_if if4 ();
  decoder_rr_arbiter_if if1 ();
  assign if4.req = req;
  assign if1.req = req;

  decoder_rr_arbiter #(.HOLD_MAX(4)) u_dut4 (.clk(gclk), .rst_n(rst_n), .bus(if4));
  decoder_rr_arbiter #(.HOLD_MAX(1)) u_dut1 (.clk(gclk), .rst_n(rst_n), .bus(if1));

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  // model: mode 0 idle, 1 granted, 2 gap; ten = cycles granted so far
  int m_mode [2];
  int m_own  [2];
  int m_last [2];
  int m_ten  [2];
  int m_addr [2];

  localparam logic [15:0] RST_VEC = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'hFF};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int hold_of(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int pick(logic [7:0] r, int last);
    for (int d = 1; d <= 8; d++)
      if (r[(last + d) % 8]) return (last + d) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_own[k] = 0; m_last[k] = 7; m_ten[k] = 0; m_addr[k] = 0;
    end
  endtask

  task automatic model_step(input logic [7:0] r);
    int p;
    logic [7:0] others;
    for (int k = 0; k < 2; k++) begin
      if (m_mode[k] == 1) begin
        others = r;
        others[m_own[k]] = 1'b0;
        if (!r[m_own[k]]) m_mode[k] = 2;
        else if (m_ten[k] >= hold_of(k) && others != 8'h00) m_mode[k] = 2;
        else m_ten[k]++;
      end else begin
        p = pick(r, m_last[k]);
        if (p >= 0) begin
          m_mode[k] = 1; m_own[k] = p; m_last[k] = p; m_addr[k] = p; m_ten[k] = 1;
        end else begin
          m_mode[k] = 0;
        end
      end
    end
  endtask

  function automatic logic [15:0] exp_vec(int k);
    logic [2:0] a;
    a = 3'(m_addr[k]);
    if (m_mode[k] == 1) return {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, a, ~(8'b1 << a)};
    return {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, a, 8'hFF};
  endfunction

  function automatic logic [15:0] obs_vec(int k);
    if (k == 0)
      return {1'b0, if4.gnt_valid, if4.G1, if4.G2A, if4.G2B, if4.A2, if4.A1, if4.A0, if4.Y};
    return {1'b0, if1.gnt_valid, if1.G1, if1.G2A, if1.G2B, if1.A2, if1.A1, if1.A0, if1.Y};
  endfunction

  // Y must be all-high, or exactly one low bit while G1 is high.
  function automatic logic y_ok(logic [7:0] y, logic g1);
    return (y == 8'hFF) || ($countones(~y) == 1 && g1);
  endfunction

  task automatic step();
    @(posedge gclk);
    model_step(req);
    @(negedge gclk);
    chk("h4_lines", obs_vec(0), exp_vec(0));
    chk("h1_lines", obs_vec(1), exp_vec(1));
    chk("h4_yshape", {15'd0, y_ok(if4.Y, if4.G1)}, 16'd1);
    chk("h1_yshape", {15'd0, y_ok(if1.Y, if1.G1)}, 16'd1);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic async_reset(input string tag);
    #3 rst_n = 1'b0;
    #1;
    chk({tag, "_h4"}, obs_vec(0), RST_VEC);
    chk({tag, "_h1"}, obs_vec(1), RST_VEC);
    model_reset();
    @(posedge gclk);
    @(negedge gclk);
    rst_n = 1'b1;
  endtask

  initial begin
    req   = 8'h00;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge gclk);
    chk("por_h4", obs_vec(0), RST_VEC);
    rst_n = 1'b1;
    steps(2);

    // single requester on channel 3
    req = 8'h08;
    step();
    chk("single_Y", {8'h00, if4.Y}, 16'h00F7);
    chk("single_addr", {13'd0, if4.A2, if4.A1, if4.A0}, 16'd3);
    steps(9);
    req = 8'h00;
    step();
    chk("single_gap", {8'h00, if4.Y}, 16'h00FF);
    steps(2);

    // contention 1 vs 5
    req = 8'h22;
    steps(22);
    req = 8'h00;
    steps(3);

    // early release of channel 2 with channel 6 waiting
    req = 8'h04;
    step();
    req = 8'h44;
    steps(2);
    req = 8'h40;
    step();
    chk("early_gap", {8'h00, if4.Y}, 16'h00FF);
    step();
    chk("early_Y", {8'h00, if4.Y}, 16'h00BF);
    chk("early_addr", {13'd0, if4.A2, if4.A1, if4.A0}, 16'd6);
    req = 8'h00;
    steps(3);

    // everyone requests: strict rotation on the HOLD_MAX=1 instance
    req = 8'hFF;
    steps(24);
    req = 8'h00;
    steps(3);

    // reset in the middle of channel 4's grant
    req = 8'h10;
    steps(2);
    req = 8'h11;
    step();
    async_reset("midgrant_rst");
    step();
    chk("post_rst_Y", {8'h00, if4.Y}, 16'h00FE);
    steps(10);

    // randomized sticky requests, occasional full reshuffles
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) req = 8'($urandom);
      else
        for (int b = 0; b < 8; b++)
          if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      step();
      if (i == 200) async_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
